// File: rtl/dram_req_arbiter.sv
// dram_req_arbiter: merges a read and a write request stream into a single
// memory request port using round-robin arbitration, then forwards the write
// data beats of a granted write burst before accepting any further request.
module dram_req_arbiter #(
  parameter int ADDR_W = 64,
  parameter int ID_W   = 8,
  parameter int LEN_W  = 8,
  parameter int DATA_W = 128
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // read request
  input  logic              rd_req_valid_i,
  output logic              rd_req_ready_o,
  input  logic [ADDR_W-1:0] rd_req_addr_i,
  input  logic [ID_W-1:0]   rd_req_id_i,
  input  logic [LEN_W-1:0]  rd_req_len_i,
  // write request
  input  logic              wr_req_valid_i,
  output logic              wr_req_ready_o,
  input  logic [ADDR_W-1:0] wr_req_addr_i,
  input  logic [ID_W-1:0]   wr_req_id_i,
  input  logic [LEN_W-1:0]  wr_req_len_i,
  // write data
  input  logic              wr_data_valid_i,
  output logic              wr_data_ready_o,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_data_last_i,
  // merged request toward memory
  output logic              ext_req_valid_o,
  input  logic              ext_req_ready_i,
  output logic [ADDR_W-1:0] ext_req_addr_o,
  output logic [ID_W-1:0]   ext_req_id_o,
  output logic [LEN_W-1:0]  ext_req_len_o,
  output logic              ext_req_we_o,
  // write data toward memory
  output logic              ext_data_valid_o,
  input  logic              ext_data_ready_i,
  output logic [DATA_W-1:0] ext_data_o,
  output logic              ext_data_last_o,
  // sticky burst-length mismatch
  output logic              err_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WDATA = 2'd2;

  logic [1:0]        state_reg, state_next;
  logic              prefer_wr_reg, prefer_wr_next;   // 1: write wins a tie
  logic [LEN_W-1:0]  cnt_reg, cnt_next;               // beats left minus one
  logic              err_reg, err_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ID_W-1:0]   id_reg, id_next;
  logic [LEN_W-1:0]  len_reg, len_next;
  logic              we_reg, we_next;

  logic rd_grant;
  logic wr_grant;
  logic in_wdata;
  logic data_hs;
  logic cnt_zero;

  // Grant at most one requester, only while idle and out of reset
  always_comb begin
    rd_grant = 1'b0;
    wr_grant = 1'b0;
    if (state_reg == ST_IDLE && !rst_i) begin
      if (rd_req_valid_i && (!wr_req_valid_i || !prefer_wr_reg)) begin
        rd_grant = 1'b1;
      end else if (wr_req_valid_i) begin
        wr_grant = 1'b1;
      end
    end
  end

  assign rd_req_ready_o = rd_grant;
  assign wr_req_ready_o = wr_grant;

  // Write data is a combinational pass-through, gated to the data phase
  assign cnt_zero         = (cnt_reg == '0);
  assign in_wdata         = (state_reg == ST_WDATA) && !rst_i;
  assign ext_data_valid_o = in_wdata && wr_data_valid_i;
  assign wr_data_ready_o  = in_wdata && ext_data_ready_i;
  assign ext_data_o       = wr_data_i;
  assign ext_data_last_o  = cnt_zero;
  assign data_hs          = in_wdata && wr_data_valid_i && ext_data_ready_i;

  assign ext_req_valid_o = (state_reg == ST_REQ) && !rst_i;
  assign ext_req_addr_o  = addr_reg;
  assign ext_req_id_o    = id_reg;
  assign ext_req_len_o   = len_reg;
  assign ext_req_we_o    = we_reg;
  assign err_o           = err_reg;

  // Next-state, request capture and burst-count logic
  always_comb begin
    state_next     = state_reg;
    prefer_wr_next = prefer_wr_reg;
    cnt_next       = cnt_reg;
    err_next       = err_reg;
    addr_next      = addr_reg;
    id_next        = id_reg;
    len_next       = len_reg;
    we_next        = we_reg;
    case (state_reg)
      ST_IDLE: begin
        if (rd_grant) begin
          addr_next      = rd_req_addr_i;
          id_next        = rd_req_id_i;
          len_next       = rd_req_len_i;
          cnt_next       = rd_req_len_i;
          we_next        = 1'b0;
          prefer_wr_next = 1'b1;
          state_next     = ST_REQ;
        end else if (wr_grant) begin
          addr_next      = wr_req_addr_i;
          id_next        = wr_req_id_i;
          len_next       = wr_req_len_i;
          cnt_next       = wr_req_len_i;
          we_next        = 1'b1;
          prefer_wr_next = 1'b0;
          state_next     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ext_req_ready_i) begin
          state_next = we_reg ? ST_WDATA : ST_IDLE;
        end
      end
      ST_WDATA: begin
        if (data_hs) begin
          // The counter alone sequences the burst; a disagreeing last flag
          // is only recorded.
          if (wr_data_last_i != cnt_zero) begin
            err_next = 1'b1;
          end
          if (cnt_zero) begin
            state_next = ST_IDLE;
          end else begin
            cnt_next = cnt_reg - LEN_W'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Control state with synchronous reset; reset abandons any transaction
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= ST_IDLE;
      prefer_wr_reg <= 1'b0;
      cnt_reg       <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      prefer_wr_reg <= prefer_wr_next;
      cnt_reg       <= cnt_next;
      err_reg       <= err_next;
    end
  end

  // Request payload; only meaningful while ext_req_valid_o is high
  always_ff @(posedge clk_i) begin
    addr_reg <= addr_next;
    id_reg   <= id_next;
    len_reg  <= len_next;
    we_reg   <= we_next;
  end

endmodule
